// File: rtl/tt_bist_harness.sv
// LFSR-stimulus / MISR-compaction BIST harness for Tiny Tapeout user designs.
// Define BIST_EXPECT_EN to add the golden-signature comparator on pass.
module tt_bist_harness #(
  parameter int                 WIDTH        = 8,
  parameter int                 CYCLES       = 256,
  parameter int                 LAT          = 0,
  parameter logic [WIDTH-1:0]   SEED         = WIDTH'(8'h01),
  parameter logic [WIDTH-1:0]   TAPS         = WIDTH'(8'hB8),
  parameter int                 SIG_W        = 16,
  parameter logic [SIG_W-1:0]   SIG_TAPS     = SIG_W'(16'hB400),
  parameter logic [SIG_W-1:0]   EXPECTED_SIG = SIG_W'(16'h0000)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  output logic [WIDTH-1:0] stim_out,
  input  logic [WIDTH-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic             pass
);

  localparam int TOT = CYCLES + LAT;
  localparam int CW  = $clog2(TOT + 1);

  localparam logic [CW-1:0] C_CYC  = CW'(CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(TOT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_stim;
  logic [SIG_W-1:0] r_sig;
  logic             r_busy;
  logic             r_done;

  logic [CW-1:0]    w_cnt_nx;
  logic [WIDTH-1:0] w_lfsr_nx;
  logic [SIG_W-1:0] w_sig_nx;
  logic             w_stim_act;
  logic             w_absorb;
  logic             w_last;
  logic             w_launch;

  assign w_cnt_nx   = r_cnt + CW'(1);
  assign w_stim_act = r_cnt < C_CYC;
  assign w_last     = (r_state == S_RUN) && (r_cnt == C_LAST);
  assign w_launch   = ena && start && (r_state != S_RUN);

  assign w_lfsr_nx = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);

  assign w_sig_nx = (r_sig >> 1)
                  ^ (r_sig[0] ? SIG_TAPS : '0)
                  ^ SIG_W'(resp_in);

  // The first LAT cycles of a run only fill the DUT pipeline.
  if (LAT == 0) begin : g_nolat
    assign w_absorb = 1'b1;
  end else begin : g_lat
    assign w_absorb = r_cnt >= CW'(LAT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lfsr  <= SEED;
      r_stim  <= '0;
      r_sig   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (ena) begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_lfsr  <= SEED;
            r_stim  <= SEED;
            r_sig   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_RUN: begin
          r_cnt <= w_cnt_nx;
          if (w_stim_act) begin
            r_lfsr <= w_lfsr_nx;
          end
          r_stim <= (w_cnt_nx < C_CYC) ? w_lfsr_nx : '0;
          if (w_absorb) begin
            r_sig <= w_sig_nx;
          end
          if (r_cnt == C_LAST) begin
            r_state <= S_DONE;
            r_stim  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_stim  <= '0;
        end
      endcase
    end
  end

`ifdef BIST_EXPECT_EN
  logic r_pass;

  // Judged on the final MISR value, in step with done rising.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass <= 1'b0;
    end else if (w_launch) begin
      r_pass <= 1'b0;
    end else if (ena && w_last) begin
      r_pass <= (w_absorb ? w_sig_nx : r_sig) == EXPECTED_SIG;
    end
  end

  assign pass = r_pass;
`else
  localparam logic unused_exp = ^EXPECTED_SIG;
  logic unused_w;
  assign unused_w = w_launch ^ w_last;
  assign pass = 1'b0;
`endif

  assign stim_out  = r_stim;
  assign busy      = r_busy;
  assign done      = r_done;
  assign signature = r_sig;

endmodule
